instr_bank_arbiter: RTL and testbench

Read-side arbiter and return path for instruction memory shared by several CPUs and split into single-port banks. Each cycle it decodes every CPU fetch address into bank number plus bank-local address, picks one CPU per bank by round-robin, and drives that bank's read port. One cycle later it steers the bank's read data back to the winning CPU with a valid strobe. It sits between the CPU fetch ports and the bank memories, which have synchronous read with 1-cycle latency.

---
 rtl/instr_bank_arbiter.sv | 124 ++++++++++++
 tb/tb_instr_bank_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_bank_arbiter.sv
// Round-robin read arbiter for banked instruction memory shared by several CPUs.
// Define INSTR_BANK_ARB_RDATA_REG_EN to register the return path (2-cycle grant-to-data).
module instr_bank_arbiter #(
    parameter int NUM_CPUS           = 3,
    parameter int NUM_BANKS          = 3,
    parameter int SIZE_BANKI         = 32,
    parameter int DATA_W             = 32,
    parameter int SHIRINA_BANKI      = $clog2(SIZE_BANKI),
    parameter int SHIRINA_VSEH_BANOK = $clog2(SIZE_BANKI * NUM_BANKS)
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [NUM_CPUS-1:0]                           cpu_req,
    input  logic [NUM_CPUS-1:0][SHIRINA_VSEH_BANOK-1:0]   cpu_adr,
    output logic [NUM_CPUS-1:0]                           cpu_gnt,
    output logic [NUM_CPUS-1:0]                           cpu_rvalid,
    output logic [NUM_CPUS-1:0][DATA_W-1:0]               cpu_rdata,
    output logic [NUM_BANKS-1:0]                          bank_re,
    output logic [NUM_BANKS-1:0][SHIRINA_BANKI-1:0]       bank_ra,
    input  logic [NUM_BANKS-1:0][DATA_W-1:0]              bank_rd
);

    localparam int CPU_W  = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1;
    localparam int BSEL_W = SHIRINA_VSEH_BANOK - SHIRINA_BANKI;

    // Handshake: cpu_req/cpu_adr are held by the CPU until cpu_gnt is seen high in
    // the same cycle; a grant is a completed transfer and exactly one cpu_rvalid
    // pulse follows it, unless reset intervenes.

    logic [NUM_CPUS-1:0][BSEL_W-1:0]        bank_sel;
    logic [NUM_CPUS-1:0][SHIRINA_BANKI-1:0] local_adr;
    logic [NUM_CPUS-1:0]                    oor_req;
    logic [NUM_BANKS-1:0][CPU_W-1:0]        rr_ptr;
    logic [NUM_BANKS-1:0][CPU_W-1:0]        win;
    logic [NUM_BANKS-1:0][CPU_W-1:0]        owner;
    logic [NUM_BANKS-1:0]                   owner_v;
    logic [NUM_CPUS-1:0]                    oor_v;
    logic [NUM_CPUS-1:0]                    ret_v;
    logic [NUM_CPUS-1:0][DATA_W-1:0]        ret_d;

    // Extra MSB on the compare so a bank count equal to 2**BSEL_W cannot wrap to 0.
    always_comb begin
        for (int c = 0; c < NUM_CPUS; c++) begin
            bank_sel[c]  = cpu_adr[c][SHIRINA_VSEH_BANOK-1:SHIRINA_BANKI];
            local_adr[c] = cpu_adr[c][SHIRINA_BANKI-1:0];
            oor_req[c]   = cpu_req[c] &&
                           ({1'b0, bank_sel[c]} >= (BSEL_W+1)'(NUM_BANKS));
        end
    end

    always_comb begin
        logic [CPU_W:0]   scan;
        logic [CPU_W-1:0] idx;
        bank_re = '0;
        bank_ra = '0;
        win     = '0;
        cpu_gnt = oor_req;
        scan    = '0;
        idx     = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int k = 0; k < NUM_CPUS; k++) begin
                scan = {1'b0, rr_ptr[b]} + (CPU_W+1)'(k);
                if (scan >= (CPU_W+1)'(NUM_CPUS))
                    scan = scan - (CPU_W+1)'(NUM_CPUS);
                idx = scan[CPU_W-1:0];
                if (!bank_re[b] && cpu_req[idx] && bank_sel[idx] == BSEL_W'(b)) begin
                    bank_re[b]   = 1'b1;
                    bank_ra[b]   = local_adr[idx];
                    win[b]       = idx;
                    cpu_gnt[idx] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            owner   <= '0;
            owner_v <= '0;
            oor_v   <= '0;
        end else begin
            owner_v <= bank_re;
            owner   <= win;
            oor_v   <= oor_req;
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (bank_re[b])
                    rr_ptr[b] <= (win[b] == CPU_W'(NUM_CPUS - 1)) ? '0 : win[b] + CPU_W'(1);
            end
        end
    end

    // A CPU is granted at most once per cycle, so at most one source matches here.
    always_comb begin
        for (int c = 0; c < NUM_CPUS; c++) begin
            ret_v[c] = oor_v[c];
            ret_d[c] = '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (owner_v[b] && owner[b] == CPU_W'(c)) begin
                    ret_v[c] = 1'b1;
                    ret_d[c] = bank_rd[b];
                end
            end
        end
    end

`ifdef INSTR_BANK_ARB_RDATA_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rvalid <= '0;
            cpu_rdata  <= '0;
        end else begin
            cpu_rvalid <= ret_v;
            cpu_rdata  <= ret_d;
        end
    end
`else
    always_comb begin
        cpu_rvalid = ret_v;
        cpu_rdata  = ret_d;
    end
`endif

endmodule

// File: tb/tb_instr_bank_arbiter.sv
// Bench for instr_bank_arbiter: directed scenarios plus random traffic against a
// reference model of round-robin banks and a memory image.
module tb_instr_bank_arbiter;

    localparam int NC = 3;
    localparam int NB = 3;
    localparam int SB = 32;
    localparam int DW = 32;
    localparam int BW = 5;
    localparam int AW = 7;
`ifdef INSTR_BANK_ARB_RDATA_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NC-1:0]         cpu_req;
    logic [NC-1:0][AW-1:0] cpu_adr;
    logic [NC-1:0]         cpu_gnt;
    logic [NC-1:0]         cpu_rvalid;
    logic [NC-1:0][DW-1:0] cpu_rdata;
    logic [NB-1:0]         bank_re;
    logic [NB-1:0][BW-1:0] bank_ra;
    logic [NB-1:0][DW-1:0] bank_rd;

    instr_bank_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_adr    (cpu_adr),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .bank_re    (bank_re),
        .bank_ra    (bank_ra),
        .bank_rd    (bank_rd)
    );

    // bank memories: synchronous read, junk on idle cycles
    logic [DW-1:0] mem [NB][SB];
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++)
            bank_rd[b] <= bank_re[b] ? mem[b][bank_ra[b]] : DW'($urandom());
    end

    // scoreboard state
    typedef struct packed {
        logic [31:0]   due;
        logic [7:0]    cpu;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rr[NB];
    logic [NC-1:0]         m_gnt;
    logic [NC-1:0]         last_gnt;
    logic [NC-1:0]         last_rvalid;
    logic [NC-1:0][DW-1:0] last_rdata;
    logic [NB-1:0]         last_re;
    logic [NB-1:0][BW-1:0] last_ra;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Model: per-bank rotating priority, memory image lookup, fixed return latency.
    task automatic check_cycle();
        int win[NB];
        int c;
        logic [NC-1:0] eg;
        logic [NC-1:0] ev;
        logic [DW-1:0] ed[NC];
        exp_t keep[$];
        eg = '0;
        ev = '0;
        for (int i = 0; i < NC; i++) begin
            ed[i] = '0;
            if (cpu_req[i] && int'(cpu_adr[i]) / SB >= NB) eg[i] = 1'b1;
        end
        for (int b = 0; b < NB; b++) begin
            win[b] = -1;
            for (int k = 0; k < NC; k++) begin
                c = (rr[b] + k) % NC;
                if (win[b] < 0 && cpu_req[c] && int'(cpu_adr[c]) / SB == b) win[b] = c;
            end
            if (win[b] >= 0) eg[win[b]] = 1'b1;
        end

        last_gnt    = cpu_gnt;
        last_rvalid = cpu_rvalid;
        last_rdata  = cpu_rdata;
        last_re     = bank_re;
        last_ra     = bank_ra;

        chk("gnt", 64'(cpu_gnt), 64'(eg));
        for (int b = 0; b < NB; b++) begin
            chk($sformatf("bank_re%0d", b), 64'(bank_re[b]), 64'(win[b] >= 0));
            chk($sformatf("bank_ra%0d", b), 64'(bank_ra[b]),
                (win[b] >= 0) ? 64'(int'(cpu_adr[win[b]]) % SB) : 64'(0));
        end

        foreach (exp_q[i]) begin
            if (int'(exp_q[i].due) == cyc) begin
                ev[exp_q[i].cpu] = 1'b1;
                ed[exp_q[i].cpu] = exp_q[i].data;
            end else if (int'(exp_q[i].due) > cyc) begin
                keep.push_back(exp_q[i]);
            end
        end
        exp_q = keep;
        chk("rvalid", 64'(cpu_rvalid), 64'(ev));
        for (int i = 0; i < NC; i++)
            chk($sformatf("rdata%0d", i), 64'(cpu_rdata[i]), 64'(ed[i]));

        if (rst_n) begin
            for (int b = 0; b < NB; b++) begin
                if (win[b] >= 0) begin
                    rr[b] = (win[b] + 1) % NC;
                    exp_q.push_back('{due: 32'(cyc + LAT), cpu: 8'(win[b]),
                                      data: mem[b][int'(cpu_adr[win[b]]) % SB]});
                end
            end
            for (int i = 0; i < NC; i++)
                if (cpu_req[i] && int'(cpu_adr[i]) / SB >= NB)
                    exp_q.push_back('{due: 32'(cyc + LAT), cpu: 8'(i), data: '0});
        end
        m_gnt = eg;
    endtask

    // driver tasks
    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        cpu_req = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        for (int b = 0; b < NB; b++) rr[b] = 0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        cpu_req = '0;
        cpu_adr = '0;
        m_gnt   = '0;
        for (int b = 0; b < NB; b++) begin
            rr[b] = 0;
            for (int w = 0; w < SB; w++) mem[b][w] = DW'($urandom());
        end
        mem[0][5] = 32'h0000_00A5;

        // reset state
        idle(2);
        chk("reset_rvalid", 64'(last_rvalid), 64'(0));
        chk("reset_rdata0", 64'(last_rdata[0]), 64'(0));
        chk("reset_re", 64'(last_re), 64'(0));
        rst_n = 1'b1;
        idle(1);

        // single fetch from bank 0
        cpu_req = 3'b001;
        cpu_adr[0] = 7'd5;
        step();
        chk("tp1_gnt", 64'(last_gnt), 64'(3'b001));
        chk("tp1_re", 64'(last_re), 64'(3'b001));
        chk("tp1_ra", 64'(last_ra[0]), 64'(5));
        cpu_req = '0;
        for (int i = 1; i < LAT; i++) begin
            step();
            chk("tp1_early_rvalid", 64'(last_rvalid), 64'(0));
        end
        step();
        chk("tp1_rvalid", 64'(last_rvalid), 64'(3'b001));
        chk("tp1_rdata", 64'(last_rdata[0]), 64'(32'hA5));
        idle(2);

        // three CPUs, three banks, same cycle
        cpu_req = 3'b111;
        cpu_adr[0] = 7'd3;
        cpu_adr[1] = 7'd35;
        cpu_adr[2] = 7'd70;
        step();
        chk("tp2_gnt", 64'(last_gnt), 64'(3'b111));
        chk("tp2_ra0", 64'(last_ra[0]), 64'(3));
        chk("tp2_ra1", 64'(last_ra[1]), 64'(3));
        chk("tp2_ra2", 64'(last_ra[2]), 64'(6));
        cpu_req = '0;
        for (int i = 1; i < LAT; i++) step();
        step();
        chk("tp2_rvalid", 64'(last_rvalid), 64'(3'b111));
        chk("tp2_rdata0", 64'(last_rdata[0]), 64'(mem[0][3]));
        chk("tp2_rdata1", 64'(last_rdata[1]), 64'(mem[1][3]));
        chk("tp2_rdata2", 64'(last_rdata[2]), 64'(mem[2][6]));
        idle(2);

        // persistent contention on bank 1 from a fresh reset
        do_reset();
        cpu_req = 3'b111;
        cpu_adr[0] = 7'd32;
        cpu_adr[1] = 7'd40;
        cpu_adr[2] = 7'd63;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("tp3_rr%0d", i), 64'(last_gnt), 64'(1 << (i % NC)));
        end
        idle(3);

        // out-of-range address
        cpu_req = 3'b100;
        cpu_adr[2] = 7'd100;
        step();
        chk("tp4_gnt", 64'(last_gnt), 64'(3'b100));
        chk("tp4_re", 64'(last_re), 64'(0));
        cpu_req = '0;
        for (int i = 1; i < LAT; i++) step();
        step();
        chk("tp4_rvalid", 64'(last_rvalid), 64'(3'b100));
        chk("tp4_rdata", 64'(last_rdata[2]), 64'(0));
        idle(2);

        // reset right after a grant discards its return
        cpu_req = 3'b010;
        cpu_adr[1] = 7'd7;
        @(negedge clk);
        check_cycle();
        chk("tp5_gnt", 64'(last_gnt), 64'(3'b010));
        rst_n = 1'b0;
        exp_q.delete();
        for (int b = 0; b < NB; b++) rr[b] = 0;
        @(posedge clk);
        #1;
        cyc++;
        cpu_req = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("tp5_rvalid_low", 64'(last_rvalid), 64'(0));
        end
        rst_n = 1'b1;
        idle(1);
        chk("tp5_rvalid_after", 64'(last_rvalid), 64'(0));
        cpu_req = 3'b111;
        cpu_adr[0] = 7'd1;
        cpu_adr[1] = 7'd2;
        cpu_adr[2] = 7'd3;
        step();
        chk("tp5_first_cpu0", 64'(last_gnt), 64'(3'b001));
        idle(3);

        // random traffic; losers hold their request until granted
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
                m_gnt = '0;
            end
            for (int c = 0; c < NC; c++) begin
                if (!(cpu_req[c] && !m_gnt[c])) begin
                    cpu_req[c] = ($urandom_range(0, 3) != 0);
                    cpu_adr[c] = ($urandom_range(0, 2) == 0) ?
                                 AW'($urandom_range(32, 63)) : AW'($urandom_range(0, 127));
                end
            end
            step();
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
